// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/secondary-master arbiter for the single-port synchronous-read dmem
// Optional per-port grant counters are compiled in when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic [DATA_W-1:0] x_rdata,
  output logic              x_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       c_grant_cnt,
  output logic [15:0]       x_grant_cnt
`endif
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q;
  logic              owner_x_q;
  logic [WCW-1:0]    wait_cnt_q;
  logic [WCW-1:0]    wait_cnt_d;
  logic              x_wins_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              c_ack_q;
  logic              x_ack_q;
  logic              busy_q;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] x_rdata_q;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]       c_grant_q;
  logic [15:0]       x_grant_q;
`endif

  // Winner selection and starvation counter update for the current IDLE cycle
  always_comb begin
    x_wins_d   = x_req & (~c_req | (wait_cnt_q == WAIT_MAX));
    wait_cnt_d = wait_cnt_q;
    if (x_wins_d) begin
      wait_cnt_d = '0;
    end else if (c_req && x_req && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Transaction FSM: latch winner in IDLE, drive memory in ACCESS, ack owner in DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_x_q   <= 1'b0;
      wait_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c_ack_q     <= 1'b0;
      x_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      c_rdata_q   <= '0;
      x_rdata_q   <= '0;
`ifdef DMEM_ARB_STATS_EN
      c_grant_q   <= '0;
      x_grant_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (c_req || x_req) begin
            state_q     <= ACCESS;
            busy_q      <= 1'b1;
            owner_x_q   <= x_wins_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_we_q    <= x_wins_d ? x_we    : c_we;
            mem_addr_q  <= x_wins_d ? x_addr  : c_addr;
            mem_wdata_q <= x_wins_d ? x_wdata : c_wdata;
`ifdef DMEM_ARB_STATS_EN
            if (x_wins_d) begin
              x_grant_q <= x_grant_q + 16'd1;
            end else begin
              c_grant_q <= c_grant_q + 16'd1;
            end
`endif
          end
        end
        ACCESS: begin
          state_q  <= DONE;
          mem_we_q <= 1'b0;
          c_ack_q  <= ~owner_x_q;
          x_ack_q  <= owner_x_q;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          c_ack_q <= 1'b0;
          x_ack_q <= 1'b0;
          if (owner_x_q) begin
            x_rdata_q <= mem_rdata;
          end else begin
            c_rdata_q <= mem_rdata;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          mem_we_q <= 1'b0;
          c_ack_q  <= 1'b0;
          x_ack_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read data passes the memory output through during the ack cycle, then holds
  assign c_rdata   = c_ack_q ? mem_rdata : c_rdata_q;
  assign x_rdata   = x_ack_q ? mem_rdata : x_rdata_q;
  assign c_ack     = c_ack_q;
  assign x_ack     = x_ack_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
`ifdef DMEM_ARB_STATS_EN
  assign c_grant_cnt = c_grant_q;
  assign x_grant_cnt = x_grant_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic [31:0] c_rdata;
  logic        c_ack;
  logic        x_req = 1'b0, x_we = 1'b0;
  logic [31:0] x_addr = '0, x_wdata = '0;
  logic [31:0] x_rdata;
  logic        x_ack;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] c_grant_cnt, x_grant_cnt;
`endif

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_rdata(x_rdata), .x_ack(x_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
    , .c_grant_cnt(c_grant_cnt), .x_grant_cnt(x_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input int idx);
    return (idx == 4) ? 32'hDEADBEEF : (32'h5A000000 | (idx * 32'h00010203));
  endfunction

  // Synchronous-read memory: data for the address seen at an edge appears after that edge
  logic [31:0] tbmem [64];
  logic [63:0] written = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      tbmem[mem_addr[7:2]]   <= mem_wdata;
      written[mem_addr[7:2]] <= 1'b1;
    end
    mem_rdata <= written[mem_addr[7:2]] ? tbmem[mem_addr[7:2]] : seed(int'(mem_addr[7:2]));
  end

  typedef struct {
    logic        px;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [64];
  int          passed = 0, total = 0;
  int          cyc = 0, acks = 0, last_ack_cyc = -1;
  bit          check_gap = 0;
  int          mc = 0, mx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (c_ack || x_ack) begin
      acks++;
      check("ack_exclusive", 32'(c_ack & x_ack), 32'd0);
      if (check_gap && last_ack_cyc >= 0) check("ack_gap", 32'(cyc - last_ack_cyc), 32'd3);
      last_ack_cyc = cyc;
      check("ack_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("ack_port", 32'(x_ack), 32'(e.px));
        if (!e.we) check("rdata", e.px ? x_rdata : c_rdata, e.data);
      end
    end
  endtask

  task automatic push(input logic px, input logic we, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.px = px; e.we = we; e.addr = addr;
    if (we) begin
      ref_mem[addr[7:2]] = data;
      e.data = data;
    end else begin
      e.data = ref_mem[addr[7:2]];
    end
    sbq.push_back(e);
    if (px) mx++; else mc++;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int target;
    target = acks + n;
    for (int i = 0; i < budget && acks < target; i++) tick();
    if (acks < target) check("ack_timeout", 32'(acks), 32'(target));
  endtask

  task automatic txn(input logic px, input logic we, input logic [31:0] addr, input logic [31:0] data);
    if (px) begin x_req = 1; x_we = we; x_addr = addr; x_wdata = data; end
    else begin c_req = 1; c_we = we; c_addr = addr; c_wdata = data; end
    push(px, we, addr, data);
    wait_acks(1, 8);
    c_req = 0; x_req = 0;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);

    // Reset state
    reset = 0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_c_ack", 32'(c_ack), 0);
    check("rst_x_ack", 32'(x_ack), 0);
    check("rst_c_rdata", c_rdata, 0);
    reset = 1;
    tick();

    // C read of 0x10
    c_req = 1; c_we = 0; c_addr = 32'h10;
    push(0, 0, 32'h10, 0);
    tick();
    check("c_rd_busy_access", 32'(busy), 1);
    check("c_rd_mem_addr", mem_addr, 32'h10);
    check("c_rd_mem_we", 32'(mem_we), 0);
    check("c_rd_no_ack_early", 32'(c_ack), 0);
    tick();
    check("c_rd_ack", 32'(c_ack), 1);
    check("c_rd_x_ack", 32'(x_ack), 0);
    check("c_rd_rdata", c_rdata, 32'hDEADBEEF);
    c_req = 0;
    tick();
    check("c_rd_idle_busy", 32'(busy), 0);
    check("c_rd_ack_pulse", 32'(c_ack), 0);
    check("c_rd_rdata_hold", c_rdata, 32'hDEADBEEF);

    // X write of 0x20
    x_req = 1; x_we = 1; x_addr = 32'h20; x_wdata = 32'h12345678;
    push(1, 1, 32'h20, 32'h12345678);
    tick();
    check("x_wr_mem_we", 32'(mem_we), 1);
    check("x_wr_mem_addr", mem_addr, 32'h20);
    check("x_wr_mem_wdata", mem_wdata, 32'h12345678);
    check("x_wr_busy1", 32'(busy), 1);
    tick();
    check("x_wr_mem_we_off", 32'(mem_we), 0);
    check("x_wr_ack", 32'(x_ack), 1);
    check("x_wr_busy2", 32'(busy), 1);
    check("x_wr_addr_hold", mem_addr, 32'h20);
    x_req = 0;
    tick();
    check("x_wr_busy_end", 32'(busy), 0);
    check("x_wr_ack_pulse", 32'(x_ack), 0);
    txn(0, 0, 32'h20, 0);
    txn(1, 0, 32'h10, 0);

    // Continuous contention: C,C,C,C,X,C,C,C,C,X with acks every 3 cycles
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(0, 0, 32'h40, 0);
      push(1, 0, 32'h80, 0);
    end
    c_req = 1; c_we = 0; c_addr = 32'h40;
    x_req = 1; x_we = 0; x_addr = 32'h80;
    check_gap = 1; last_ack_cyc = -1;
    wait_acks(10, 40);
    c_req = 0; x_req = 0;
    check_gap = 0;
    tick();
    check("contend_sb_drained", 32'(sbq.size()), 0);

    // Build wait_cnt up to MAX_WAIT, then reset during ACCESS of a C write
    for (int k = 0; k < 4; k++) push(0, 0, 32'h40, 0);
    c_req = 1; x_req = 1;
    wait_acks(4, 20);
    c_req = 0; x_req = 0;
    tick();
    c_req = 1; c_we = 1; c_addr = 32'h30; c_wdata = 32'hCAFEF00D;
    tick();
    check("rst_mid_mem_we_access", 32'(mem_we), 1);
    reset = 0; c_req = 0;
    mc = 0; mx = 0;
    tick();
    check("rst_mid_mem_we", 32'(mem_we), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_c_ack", 32'(c_ack), 0);
    reset = 1;
    tick();
    check("rst_mid_no_late_ack", 32'(c_ack), 0);
    check("rst_mid_idle", 32'(busy), 0);
    // With wait_cnt cleared, a contended grant goes to C
    c_we = 0; c_addr = 32'h40;
    push(0, 0, 32'h40, 0);
    c_req = 1; x_req = 1;
    wait_acks(1, 8);
    c_req = 0; x_req = 0;
    tick();

    // Reset glitch between edges is not sampled
    c_req = 1; c_we = 0; c_addr = 32'h20;
    push(0, 0, 32'h20, 0);
    tick();
    #1 reset = 0;
    #2 reset = 1;
    check("glitch_busy", 32'(busy), 1);
    wait_acks(1, 6);
    c_req = 0;
    tick();
    check("glitch_sb_drained", 32'(sbq.size()), 0);

`ifdef DMEM_ARB_STATS_EN
    check("stats_c_running", 32'(c_grant_cnt), 32'(mc));
    check("stats_x_running", 32'(x_grant_cnt), 32'(mx));
    reset = 0;
    tick();
    reset = 1;
    check("stats_rst_c", 32'(c_grant_cnt), 0);
    check("stats_rst_x", 32'(x_grant_cnt), 0);
    for (int k = 0; k < 5; k++) txn(0, 0, 32'h40, 0);
    for (int k = 0; k < 2; k++) txn(1, 0, 32'h80, 0);
    check("stats_c5", 32'(c_grant_cnt), 32'd5);
    check("stats_x2", 32'(x_grant_cnt), 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
